slot_timing_ctrl: RTL and testbench

Sequencer for the 64 kHz slot timebase on the 200 MHz domain. After the DAC SPI configuration completes, it arms the timebase, asserts the `slot_start_count` enable consumed by the divided-clock generators, and produces phase-aligned single-cycle strobes at 64 kHz, 64/3 kHz and 64/96 kHz, plus a frame slot index. It also handles stop and resync requests from the configuration logic, so every timebase consumer restarts from a common phase.

---
 rtl/slot_timing_ctrl_if.sv | 27 ++
 rtl/slot_timing_ctrl.sv | 133 +++++++++++++
 tb/tb_slot_timing_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/slot_timing_ctrl_if.sv
// rtl/slot_timing_ctrl_if.sv - control pulses and timebase outputs of slot_timing_ctrl
interface slot_timing_ctrl_if #(
    parameter int FRAME_SLOTS = 64
) ();
    localparam int IDX_W = (FRAME_SLOTS > 1) ? $clog2(FRAME_SLOTS) : 1;

    logic             spi_cfg_done;
    logic             stop_req;
    logic             resync_req;
    logic             slot_start_count;
    logic             tick_64k;
    logic             tick_mid;
    logic             tick_slot;
    logic             frame_tick;
    logic [IDX_W-1:0] slot_idx;
    logic             running;

    modport master (
        output spi_cfg_done, stop_req, resync_req,
        input  slot_start_count, tick_64k, tick_mid, tick_slot, frame_tick, slot_idx, running
    );

    modport slave (
        input  spi_cfg_done, stop_req, resync_req,
        output slot_start_count, tick_64k, tick_mid, tick_slot, frame_tick, slot_idx, running
    );
endinterface

// File: rtl/slot_timing_ctrl.sv
// rtl/slot_timing_ctrl.sv - 64 kHz slot timebase sequencer (IDLE/ARM/RUN) with phase-aligned strobes
module slot_timing_ctrl #(
    parameter int DIV_BASE    = 3125,
    parameter int DIV_MID     = 3,
    parameter int DIV_SLOT    = 96,
    parameter int FRAME_SLOTS = 64,
    parameter int ARM_DLY     = 16
) (
    input logic               clk_200m,
    input logic               cfg_rst,
    slot_timing_ctrl_if.slave ctl
);
    localparam int ARM_W  = (ARM_DLY > 1)     ? $clog2(ARM_DLY)     : 1;
    localparam int BASE_W = (DIV_BASE > 1)    ? $clog2(DIV_BASE)    : 1;
    localparam int MID_W  = (DIV_MID > 1)     ? $clog2(DIV_MID)     : 1;
    localparam int SLOT_W = (DIV_SLOT > 1)    ? $clog2(DIV_SLOT)    : 1;
    localparam int IDX_W  = (FRAME_SLOTS > 1) ? $clog2(FRAME_SLOTS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ARM_W-1:0]  arm_cnt;
    logic [BASE_W-1:0] base_cnt;
    logic [MID_W-1:0]  mid_cnt;
    logic [SLOT_W-1:0] slot_cnt;
    logic [IDX_W-1:0]  slot_idx;

    logic arm_last;
    logic run_hold;
    logic base_wrap;
    logic mid_wrap;
    logic slot_wrap;
    logic frame_wrap;

    logic run_q;
    logic tick_64k_q;
    logic tick_mid_q;
    logic tick_slot_q;
    logic frame_tick_q;

    // stop and resync both break the phase chain, so they also gate every wrap and strobe
    assign arm_last   = (state == ST_ARM) && (arm_cnt == ARM_W'(ARM_DLY - 1));
    assign run_hold   = (state == ST_RUN) && !ctl.stop_req && !ctl.resync_req;
    assign base_wrap  = run_hold && (base_cnt == BASE_W'(DIV_BASE - 1));
    assign mid_wrap   = base_wrap && (mid_cnt == MID_W'(DIV_MID - 1));
    assign slot_wrap  = base_wrap && (slot_cnt == SLOT_W'(DIV_SLOT - 1));
    assign frame_wrap = slot_wrap && (slot_idx == IDX_W'(FRAME_SLOTS - 1));

    always_ff @(posedge clk_200m or posedge cfg_rst) begin
        if (cfg_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (ctl.spi_cfg_done && !ctl.stop_req) begin
                    state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                if (ctl.stop_req) begin
                    state_nxt = ST_IDLE;
                end else if (arm_last) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ctl.stop_req) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_200m or posedge cfg_rst) begin
        if (cfg_rst) begin
            arm_cnt      <= '0;
            base_cnt     <= '0;
            mid_cnt      <= '0;
            slot_cnt     <= '0;
            slot_idx     <= '0;
            run_q        <= 1'b0;
            tick_64k_q   <= 1'b0;
            tick_mid_q   <= 1'b0;
            tick_slot_q  <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            arm_cnt <= ((state == ST_ARM) && (state_nxt == ST_ARM)) ? arm_cnt + 1'b1 : '0;

            if (!run_hold) begin
                base_cnt <= '0;
                mid_cnt  <= '0;
                slot_cnt <= '0;
                slot_idx <= '0;
            end else begin
                base_cnt <= base_wrap ? '0 : base_cnt + 1'b1;
                if (base_wrap) begin
                    mid_cnt  <= mid_wrap  ? '0 : mid_cnt + 1'b1;
                    slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
                end
                if (slot_wrap) begin
                    slot_idx <= frame_wrap ? '0 : slot_idx + 1'b1;
                end
            end

            run_q        <= (state_nxt == ST_RUN);
            tick_64k_q   <= base_wrap;
            tick_mid_q   <= mid_wrap;
            tick_slot_q  <= slot_wrap;
            frame_tick_q <= frame_wrap;
        end
    end

    assign ctl.slot_start_count = run_q;
    assign ctl.running          = run_q;
    assign ctl.tick_64k         = tick_64k_q;
    assign ctl.tick_mid         = tick_mid_q;
    assign ctl.tick_slot        = tick_slot_q;
    assign ctl.frame_tick       = frame_tick_q;
    assign ctl.slot_idx         = slot_idx;
endmodule

// File: tb/tb_slot_timing_ctrl.sv
// tb/tb_slot_timing_ctrl.sv - self-checking bench for slot_timing_ctrl, default and shortened timebases
module tb_slot_timing_ctrl;
    localparam int A_BASE = 3125;
    localparam int B_BASE = 10;
    localparam int N_MID  = 3;
    localparam int N_SLOT = 96;
    localparam int A_FS   = 64;
    localparam int B_FS   = 4;
    localparam int N_ARM  = 16;

    localparam int S_SSC  = 0;
    localparam int S_RUN  = 1;
    localparam int S_T64  = 2;
    localparam int S_MID  = 3;
    localparam int S_SLOT = 4;
    localparam int S_FRM  = 5;

    logic clk_200m = 1'b0;
    logic cfg_rst  = 1'b1;
    int   cyc      = 0;
    int   checks   = 0;
    int   errors   = 0;

    // model: mode 0 idle, 1 arm, 2 run; m_arm = edge ARM began, m_org = edge phase origin
    int m_mode [2] = '{0, 0};
    int m_arm  [2] = '{0, 0};
    int m_org  [2] = '{0, 0};

    slot_timing_ctrl_if #(.FRAME_SLOTS(A_FS)) ifa ();
    slot_timing_ctrl_if #(.FRAME_SLOTS(B_FS)) ifb ();

    slot_timing_ctrl #(
        .DIV_BASE(A_BASE), .DIV_MID(N_MID), .DIV_SLOT(N_SLOT), .FRAME_SLOTS(A_FS), .ARM_DLY(N_ARM)
    ) dut_a (
        .clk_200m(clk_200m),
        .cfg_rst (cfg_rst),
        .ctl     (ifa)
    );

    slot_timing_ctrl #(
        .DIV_BASE(B_BASE), .DIV_MID(N_MID), .DIV_SLOT(N_SLOT), .FRAME_SLOTS(B_FS), .ARM_DLY(N_ARM)
    ) dut_b (
        .clk_200m(clk_200m),
        .cfg_rst (cfg_rst),
        .ctl     (ifb)
    );

    always #5 clk_200m = ~clk_200m;

    always @(posedge clk_200m) cyc <= cyc + 1;

    function automatic logic in_spi(input int i);
        return (i == 0) ? ifa.spi_cfg_done : ifb.spi_cfg_done;
    endfunction

    function automatic logic in_stop(input int i);
        return (i == 0) ? ifa.stop_req : ifb.stop_req;
    endfunction

    function automatic logic in_rsy(input int i);
        return (i == 0) ? ifa.resync_req : ifb.resync_req;
    endfunction

    always @(posedge clk_200m or posedge cfg_rst) begin
        if (cfg_rst) begin
            m_mode[0] <= 0;
            m_mode[1] <= 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (m_mode[i])
                    0: if (in_spi(i) && !in_stop(i)) begin
                        m_mode[i] <= 1;
                        m_arm[i]  <= cyc + 1;
                    end
                    1: if (in_stop(i)) begin
                        m_mode[i] <= 0;
                    end else if (cyc + 1 - m_arm[i] == N_ARM) begin
                        m_mode[i] <= 2;
                        m_org[i]  <= cyc + 1;
                    end
                    2: if (in_stop(i)) begin
                        m_mode[i] <= 0;
                    end else if (in_rsy(i)) begin
                        m_org[i] <= cyc + 1;
                    end
                    default: m_mode[i] <= 0;
                endcase
            end
        end
    end

    // expected outputs follow purely from elapsed cycles since the phase origin
    function automatic logic [11:0] exp_vec(input int i);
        int   d;
        int   fs;
        int   n;
        int   k;
        int   idx;
        logic t64;
        logic tmid;
        logic tsl;
        logic ftk;
        if (m_mode[i] != 2) return 12'd0;
        d    = (i == 0) ? A_BASE : B_BASE;
        fs   = (i == 0) ? A_FS : B_FS;
        n    = cyc - m_org[i];
        k    = n / d;
        t64  = (n > 0) && (n % d == 0);
        tmid = t64 && (k % N_MID == 0);
        tsl  = t64 && (k % N_SLOT == 0);
        idx  = (n / (d * N_SLOT)) % fs;
        ftk  = tsl && (idx == 0);
        return {1'b1, 1'b1, t64, tmid, tsl, ftk, 6'(idx)};
    endfunction

    function automatic logic [11:0] got_vec(input int i);
        if (i == 0)
            return {ifa.slot_start_count, ifa.running, ifa.tick_64k, ifa.tick_mid,
                    ifa.tick_slot, ifa.frame_tick, ifa.slot_idx};
        return {ifb.slot_start_count, ifb.running, ifb.tick_64k, ifb.tick_mid,
                ifb.tick_slot, ifb.frame_tick, 4'd0, ifb.slot_idx};
    endfunction

    function automatic logic sig(input int i, input int s);
        logic [11:0] g;
        g = got_vec(i);
        return g[11 - s];
    endfunction

    function automatic int cur_idx(input int i);
        logic [11:0] g;
        g = got_vec(i);
        return int'(g[5:0]);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got_vec(i) !== exp_vec(i)) begin
                errors++;
                $display("FAIL model inst%0d cyc %0d got %h expected %h", i, cyc, got_vec(i), exp_vec(i));
            end
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(negedge clk_200m);
            compare_all();
        end
    endtask

    task automatic set_in(input int i, input logic spi, input logic stp, input logic rsy);
        if (i == 0) begin
            ifa.spi_cfg_done = spi;
            ifa.stop_req     = stp;
            ifa.resync_req   = rsy;
        end else begin
            ifb.spi_cfg_done = spi;
            ifb.stop_req     = stp;
            ifb.resync_req   = rsy;
        end
    endtask

    task automatic pulse(input int i, input logic spi, input logic stp, input logic rsy);
        set_in(i, spi, stp, rsy);
        run_cycles(1);
        set_in(i, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_sig(input int i, input int s, input int budget, output int at);
        at = -1;
        for (int c = 0; c < budget; c++) begin
            run_cycles(1);
            if (sig(i, s)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL timeout inst%0d signal %0d got none expected strobe within %0d", i, s, budget);
        end
    endtask

    initial begin
        int p, r, t1, t2, y, tn;
        int n64, nmid, nslot, ncoin, nfrm_early, prev_idx;

        set_in(0, 1'b0, 1'b0, 1'b0);
        set_in(1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk_200m);
        cfg_rst = 1'b0;
        check("reset_a", 32'(got_vec(0)), 0);
        check("reset_b", 32'(got_vec(1)), 0);

        // shortened timebase: bring-up, divider relationships, frame wrap
        p = cyc;
        pulse(1, 1'b1, 1'b0, 1'b0);
        wait_sig(1, S_SSC, 100, r);
        check("b_start_latency", r - p, 17);
        n64 = 0; nmid = 0; nslot = 0; ncoin = 0;
        for (int c = 0; c < 96 * B_BASE; c++) begin
            run_cycles(1);
            if (sig(1, S_T64)) n64++;
            if (sig(1, S_MID)) begin
                nmid++;
                if (!sig(1, S_T64)) ncoin++;
            end
            if (sig(1, S_SLOT)) begin
                nslot++;
                if (!sig(1, S_T64)) ncoin++;
            end
        end
        check("b_tick64_count", n64, 96);
        check("b_tickmid_count", nmid, 32);
        check("b_tickslot_count", nslot, 1);
        check("b_coincidence", ncoin, 0);
        check("b_idx_after_slot", cur_idx(1), 1);
        nfrm_early = 0;
        for (int c = 0; c < 4000 && nslot < 4; c++) begin
            prev_idx = cur_idx(1);
            run_cycles(1);
            if (sig(1, S_SLOT)) begin
                nslot++;
                if (nslot == 4) begin
                    check("b_frame_tick", sig(1, S_FRM), 1);
                    check("b_idx_before_wrap", prev_idx, 3);
                    check("b_idx_after_wrap", cur_idx(1), 0);
                end else if (sig(1, S_FRM)) begin
                    nfrm_early++;
                end
            end
        end
        check("b_slot_ticks_seen", nslot, 4);
        check("b_frame_early", nfrm_early, 0);

        for (int c = 0; c < 20000; c++) begin
            set_in(1, $urandom_range(0, 399) == 0, $urandom_range(0, 2999) == 0,
                   $urandom_range(0, 1499) == 0);
            run_cycles(1);
        end
        set_in(1, 1'b0, 1'b0, 1'b0);
        pulse(1, 1'b0, 1'b1, 1'b0);

        // default timebase: bring-up and tick period
        p = cyc;
        pulse(0, 1'b1, 1'b0, 1'b0);
        wait_sig(0, S_SSC, 100, r);
        check("a_start_latency", r - p, 17);
        wait_sig(0, S_T64, 4000, t1);
        check("a_first_tick", t1 - r, 3125);
        wait_sig(0, S_T64, 4000, t2);
        check("a_tick_period", t2 - t1, 3125);

        // resync sampled 5 cycles before the base wrap
        run_cycles(t2 + A_BASE - 6 - cyc);
        y = cyc;
        pulse(0, 1'b0, 1'b0, 1'b1);
        wait_sig(0, S_T64, 4000, tn);
        check("a_resync_tick", tn - y, 3126);
        check("a_resync_idx", cur_idx(0), 0);

        // stop together with resync on the wrap edge
        run_cycles(tn + A_BASE - 1 - cyc);
        pulse(0, 1'b0, 1'b1, 1'b1);
        check("a_stop_no_tick", sig(0, S_T64), 0);
        check("a_stop_ssc", sig(0, S_SSC), 0);
        check("a_stop_running", sig(0, S_RUN), 0);
        pulse(0, 1'b1, 1'b1, 1'b0);
        run_cycles(30);
        check("a_stop_spi_idle", sig(0, S_SSC), 0);

        // spi_cfg_done while running must not restart the phase
        pulse(0, 1'b1, 1'b0, 1'b0);
        wait_sig(0, S_SSC, 100, r);
        wait_sig(0, S_T64, 4000, t1);
        run_cycles(1000);
        pulse(0, 1'b1, 1'b0, 1'b0);
        wait_sig(0, S_T64, 4000, t2);
        check("a_spi_in_run", t2 - t1, 3125);

        // asynchronous reset between edges
        run_cycles(100);
        check("a_pre_reset_ssc", sig(0, S_SSC), 1);
        @(posedge clk_200m);
        #2;
        cfg_rst = 1'b1;
        #1;
        check("a_async_zero", 32'(got_vec(0)), 0);
        check("b_async_zero", 32'(got_vec(1)), 0);
        run_cycles(2);
        cfg_rst = 1'b0;
        run_cycles(50);
        check("a_post_reset_idle", sig(0, S_SSC), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
